// File: rtl/sd_init_seq.sv
// sd_init_seq: SD card initialization command sequencer.
// Walks a card from power-up to the transfer state: (CMD8), CMD55/ACMD41
// polling, CMD2, CMD3 (RCA capture) and CMD7 (select), talking to an
// external CMD-line driver through a start/done handshake.
// Optional build macro SD_INIT_CMD8_EN: issue CMD8 first and request
// high capacity (HCS) in ACMD41. Without it the sequence starts at CMD55,
// ACMD41 requests standard capacity and ohcs is held at 0.
module sd_init_seq #(
  parameter logic [15:0] ACMD41_TRIES = 16'd1024,
  parameter logic [23:0] TIMEOUT      = 24'd100000
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         istart,
  output logic         ocmd_start,
  output logic [5:0]   ocmd_index,
  output logic [31:0]  ocmd_arg,
  input  logic [119:0] iresp,
  input  logic         icmd_done,
  output logic         ordy,
  output logic         ofail,
  output logic [2:0]   ofail_code,
  output logic [15:0]  orca,
  output logic         ohcs
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT_ACK, ST_WAIT_DONE, ST_CHECK, ST_READY, ST_FAIL
  } state_t;

  typedef enum logic [2:0] {
    STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD2, STEP_CMD3, STEP_CMD7
  } step_t;

`ifdef SD_INIT_CMD8_EN
  localparam step_t       FIRST_STEP = STEP_CMD8;
  localparam logic [31:0] ACMD41_ARG = 32'h40FF8000;
`else
  localparam step_t       FIRST_STEP = STEP_CMD55;
  localparam logic [31:0] ACMD41_ARG = 32'h00FF8000;
`endif

  localparam logic [2:0] CODE_BAD_ECHO = 3'd1;
  localparam logic [2:0] CODE_TRIES    = 3'd2;
  localparam logic [2:0] CODE_TIMEOUT  = 3'd3;
  localparam logic [2:0] CODE_APP_CMD  = 3'd4;

  state_t      state_q, state_d;
  step_t       step_q, step_d;
  logic [15:0] tries_q, tries_d;
  logic [23:0] timer_q, timer_d;
  logic        rdy_q, rdy_d;
  logic        fail_q, fail_d;
  logic [2:0]  code_q, code_d;
  logic [15:0] rca_q, rca_d;
  logic        hcs_q, hcs_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        istart_q;
  logic        start_edge;
  logic        adv;
  step_t       adv_step;

  // Only the short-response fields are interpreted; the rest is don't-care.
  logic unused_resp;
  assign unused_resp = ^iresp;

  function automatic logic [5:0] step_index(input step_t s);
    case (s)
      STEP_CMD8:   return 6'd8;
      STEP_CMD55:  return 6'd55;
      STEP_ACMD41: return 6'd41;
      STEP_CMD2:   return 6'd2;
      STEP_CMD3:   return 6'd3;
      STEP_CMD7:   return 6'd7;
      default:     return 6'd0;
    endcase
  endfunction

  function automatic logic [31:0] step_arg(input step_t s, input logic [15:0] rca);
    case (s)
      STEP_CMD8:   return 32'h000001AA;
      STEP_ACMD41: return ACMD41_ARG;
      STEP_CMD7:   return {rca, 16'h0000};
      default:     return 32'h00000000;
    endcase
  endfunction

  assign start_edge = istart & ~istart_q;

  assign ocmd_start = (state_q == ST_ISSUE);
  assign ocmd_index = idx_q;
  assign ocmd_arg   = arg_q;
  assign ordy       = rdy_q;
  assign ofail      = fail_q;
  assign ofail_code = code_q;
  assign orca       = rca_q;
  assign ohcs       = hcs_q;

  // Next-state logic: sequencing, handshake, timeout and response checks.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    tries_d  = tries_q;
    timer_d  = timer_q;
    rdy_d    = rdy_q;
    fail_d   = fail_q;
    code_d   = code_q;
    rca_d    = rca_q;
    hcs_d    = hcs_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    adv      = 1'b0;
    adv_step = step_q;

    case (state_q)
      ST_IDLE, ST_READY, ST_FAIL: begin
        if (start_edge) begin
          rdy_d    = 1'b0;
          fail_d   = 1'b0;
          code_d   = 3'd0;
          tries_d  = 16'd0;
          adv      = 1'b1;
          adv_step = FIRST_STEP;
        end
      end
      ST_ISSUE: begin
        // The ISSUE cycle is cycle 0 of the timeout window.
        timer_d = 24'd1;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        timer_d = timer_q + 24'd1;
        if (!icmd_done) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_d >= TIMEOUT) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          code_d  = CODE_TIMEOUT;
        end
      end
      ST_WAIT_DONE: begin
        timer_d = timer_q + 24'd1;
        if (icmd_done) begin
          state_d = ST_CHECK;
        end else if (timer_d >= TIMEOUT) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          code_d  = CODE_TIMEOUT;
        end
      end
      ST_CHECK: begin
        case (step_q)
`ifdef SD_INIT_CMD8_EN
          STEP_CMD8: begin
            if (iresp[11:8] == 4'h1 && iresp[7:0] == 8'hAA) begin
              adv      = 1'b1;
              adv_step = STEP_CMD55;
            end else begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              code_d  = CODE_BAD_ECHO;
            end
          end
`endif
          STEP_CMD55: begin
            if (iresp[5]) begin
              adv      = 1'b1;
              adv_step = STEP_ACMD41;
            end else begin
              state_d = ST_FAIL;
              fail_d  = 1'b1;
              code_d  = CODE_APP_CMD;
            end
          end
          STEP_ACMD41: begin
            if (iresp[31]) begin
`ifdef SD_INIT_CMD8_EN
              hcs_d = iresp[30];
`else
              hcs_d = 1'b0;
`endif
              adv      = 1'b1;
              adv_step = STEP_CMD2;
            end else begin
              tries_d = tries_q + 16'd1;
              if (tries_d >= ACMD41_TRIES) begin
                state_d = ST_FAIL;
                fail_d  = 1'b1;
                code_d  = CODE_TRIES;
              end else begin
                adv      = 1'b1;
                adv_step = STEP_CMD55;
              end
            end
          end
          STEP_CMD2: begin
            adv      = 1'b1;
            adv_step = STEP_CMD3;
          end
          STEP_CMD3: begin
            rca_d    = iresp[31:16];
            adv      = 1'b1;
            adv_step = STEP_CMD7;
          end
          STEP_CMD7: begin
            state_d = ST_READY;
            rdy_d   = 1'b1;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Index/argument are loaded once on entry to ISSUE and then held
    // untouched until the next command, so the driver sees stable values.
    if (adv) begin
      state_d = ST_ISSUE;
      step_d  = adv_step;
      idx_d   = step_index(adv_step);
      arg_d   = step_arg(adv_step, rca_d);
    end
  end

  // State and output registers; reset parks everything and drops all outputs.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q  <= ST_IDLE;
      step_q   <= FIRST_STEP;
      tries_q  <= 16'd0;
      timer_q  <= 24'd0;
      rdy_q    <= 1'b0;
      fail_q   <= 1'b0;
      code_q   <= 3'd0;
      rca_q    <= 16'd0;
      hcs_q    <= 1'b0;
      idx_q    <= 6'd0;
      arg_q    <= 32'd0;
      // Treat istart as already high so a level held through reset is
      // not mistaken for a fresh request.
      istart_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      tries_q  <= tries_d;
      timer_q  <= timer_d;
      rdy_q    <= rdy_d;
      fail_q   <= fail_d;
      code_q   <= code_d;
      rca_q    <= rca_d;
      hcs_q    <= hcs_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      istart_q <= istart;
    end
  end

endmodule
